// File: rtl/dmem_arbiter_if.sv
// Bundles both requester ports, the shared response data, the memory strobes and busy.
// Latency: pure wiring, no storage.
// Backpressure: requesters hold req level-high with stable fields until their one-cycle ack.
interface dmem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    // Requester 0: core load/store path
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic              m0_err;

    // Requester 1: debug/loader port
    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic              m1_err;

    // Shared read-data return, valid while either ack is high
    logic [DATA_W-1:0] rsp_rdata;

    // Data memory side
    logic              mem_memwrite;
    logic              mem_memread;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    // Environment side: requesters plus the memory array
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_err,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_err,
        input  rsp_rdata,
        input  mem_memwrite, mem_memread, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );

    // Arbiter side
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_err,
        output rsp_rdata,
        output mem_memwrite, mem_memread, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of the word-addressed data memory.
// Latency: 3 cycles from the IDLE sample of a request to its ack (IDLE, ACCESS, RESP).
// Backpressure: a losing or late requester simply keeps req high; fields are sampled only in IDLE.
module dmem_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 64
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);

    // Word index width: byte address with the two byte-lane bits dropped
    localparam int IDX_W = ADDR_W - 2;
    localparam logic [IDX_W-1:0] MEM_LIMIT = IDX_W'(MEM_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rsp_q, rsp_d;

    // Arbitration result and the selected requester's fields
    logic              gnt_any;
    logic              gnt1;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_err;

    // Round-robin pick: on contention the requester that did not win last time goes next
    always_comb begin
        gnt_any   = bus.m0_req | bus.m1_req;
        gnt1      = bus.m1_req & (~bus.m0_req | ~last_grant_q);
        sel_we    = gnt1 ? bus.m1_we    : bus.m0_we;
        sel_addr  = gnt1 ? bus.m1_addr  : bus.m0_addr;
        sel_wdata = gnt1 ? bus.m1_wdata : bus.m0_wdata;
        // Misaligned byte address or word index past the end of the array
        sel_err   = (sel_addr[1:0] != 2'b00) | (sel_addr[ADDR_W-1:2] >= MEM_LIMIT);
    end

    // State register and latched transaction context
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            rsp_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            rsp_q        <= rsp_d;
        end
    end

    // Next-state: latch the winner in IDLE, capture read data at the end of ACCESS,
    // and record the owner as last grant when the response retires
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        we_d         = we_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        rsp_d        = rsp_q;

        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    owner_d = gnt1;
                    we_d    = sel_we;
                    idx_d   = sel_addr[ADDR_W-1:2];
                    wdata_d = sel_wdata;
                    err_d   = sel_err;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Writes and faulted accesses return zero so stale data never leaks out
                rsp_d   = (~we_q & ~err_q) ? bus.mem_rdata : '0;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                last_grant_d = owner_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: memory strobes only in ACCESS, ack/err only in RESP, everything else zero
    always_comb begin
        bus.mem_memwrite = 1'b0;
        bus.mem_memread  = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_wdata    = '0;
        bus.m0_ack       = 1'b0;
        bus.m0_err       = 1'b0;
        bus.m1_ack       = 1'b0;
        bus.m1_err       = 1'b0;
        bus.rsp_rdata    = rsp_q;
        bus.busy         = (state_q != ST_IDLE);

        if (state_q == ST_ACCESS) begin
            bus.mem_addr     = {2'b00, idx_q};
            bus.mem_wdata    = wdata_q;
            bus.mem_memwrite = we_q & ~err_q;
            bus.mem_memread  = ~we_q & ~err_q;
        end

        if (state_q == ST_RESP) begin
            if (owner_q) begin
                bus.m1_ack = 1'b1;
                bus.m1_err = err_q;
            end else begin
                bus.m0_ack = 1'b1;
                bus.m0_err = err_q;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a scoreboard of expected acks.
// Latency: expectations are queued at request time and retired on each ack.
// Backpressure: requesters hold req until their ack, as the real masters do.
module tb_dmem_arbiter;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int MEM_WORDS = 64;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    dmem_arbiter #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MEM_WORDS(MEM_WORDS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Behavioural data memory: combinational read, write on the rising edge, cleared by reset
    logic [DATA_W-1:0] mem [MEM_WORDS];
    assign bus.mem_rdata = mem[bus.mem_addr[5:0]];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
        end else if (bus.mem_memwrite) begin
            mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
        end
    end

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   ack_cyc[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   cyc    = 0;
    int   wr_cnt = 0;
    int   rd_cnt = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int p, input logic err, input logic [31:0] rdata);
        exp_t e;
        e.port  = p;
        e.err   = err;
        e.rdata = rdata;
        sb.push_back(e);
    endtask

    task automatic set_req(input int p, input logic r, input logic we,
                           input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            bus.m0_req = r; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
        end else begin
            bus.m1_req = r; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
        end
    endtask

    // Counts falling edges until the given port acks, bounded
    task automatic wait_ack(input int p, output int ncyc);
        bit got;
        got  = 1'b0;
        ncyc = 0;
        while (!got && ncyc < 20) begin
            @(negedge clk);
            ncyc++;
            if ((p == 0 && bus.m0_ack) || (p == 1 && bus.m1_ack)) got = 1'b1;
        end
        chk($sformatf("ack_seen_m%0d", p), 32'(got), 32'd1);
    endtask

    // One complete transaction from an idle arbiter
    task automatic txn(input int p, input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic exp_err, input logic [31:0] exp_rd, output int lat);
        @(posedge clk); #1;
        push_exp(p, exp_err, exp_rd);
        set_req(p, 1'b1, we, a, d);
        wait_ack(p, lat);
        @(posedge clk); #1;
        set_req(p, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: strobe bookkeeping and scoreboard retirement on every ack
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_memwrite) begin
                wr_cnt++;
                last_wr_addr = bus.mem_addr;
                last_wr_data = bus.mem_wdata;
            end
            if (bus.mem_memread) rd_cnt++;
            if (bus.m0_ack || bus.m1_ack) begin
                ack_cyc.push_back(cyc);
                chk("single_ack", 32'(bus.m0_ack & bus.m1_ack), 32'd0);
                chk("ack_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("ack_port", 32'(bus.m1_ack), 32'(mon_e.port));
                    chk("ack_err", 32'(bus.m1_ack ? bus.m1_err : bus.m0_err), 32'(mon_e.err));
                    chk("other_err", 32'(bus.m1_ack ? bus.m0_err : bus.m1_err), 32'd0);
                    chk("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
                end
            end
        end
    end

    initial begin
        int lat;
        int w0;
        int r0;
        int base;
        int nack;
        int n;
        int idle_n;

        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_m0_ack",   32'(bus.m0_ack), 32'd0);
        chk("rst_m1_ack",   32'(bus.m1_ack), 32'd0);
        chk("rst_busy",     32'(bus.busy), 32'd0);
        chk("rst_memwrite", 32'(bus.mem_memwrite), 32'd0);
        chk("rst_memread",  32'(bus.mem_memread), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_rsp",      bus.rsp_rdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Write then read back through requester 0
        w0 = wr_cnt;
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0, lat);
        chk("wr_latency", 32'(lat), 32'd3);
        chk("wr_strobe_cycles", 32'(wr_cnt - w0), 32'd1);
        chk("wr_mem_addr", last_wr_addr, 32'd4);
        chk("wr_mem_wdata", last_wr_data, 32'hDEADBEEF);
        r0 = rd_cnt;
        txn(0, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF, lat);
        chk("rd_latency", 32'(lat), 32'd3);
        chk("rd_strobe_cycles", 32'(rd_cnt - r0), 32'd1);

        // Faulted accesses: misaligned, first out-of-range word, misaligned read
        w0 = wr_cnt;
        r0 = rd_cnt;
        txn(1, 1'b1, 32'h13,  32'h11111111, 1'b1, 32'd0, lat);
        txn(1, 1'b1, 32'h100, 32'h22222222, 1'b1, 32'd0, lat);
        txn(1, 1'b0, 32'h11,  32'd0,        1'b1, 32'd0, lat);
        chk("err_no_write", 32'(wr_cnt - w0), 32'd0);
        chk("err_no_read",  32'(rd_cnt - r0), 32'd0);
        // Last valid word, then the earlier data is intact
        txn(1, 1'b1, 32'hFC, 32'hA5A50001, 1'b0, 32'd0, lat);
        txn(1, 1'b0, 32'hFC, 32'd0,        1'b0, 32'hA5A50001, lat);
        txn(0, 1'b0, 32'h10, 32'd0,        1'b0, 32'hDEADBEEF, lat);

        // Fields changed after the IDLE sample are ignored
        @(posedge clk); #1;
        push_exp(0, 1'b0, 32'd0);
        set_req(0, 1'b1, 1'b1, 32'h20, 32'h22220000);
        @(posedge clk); #1;
        bus.m0_addr  = 32'h24;
        bus.m0_wdata = 32'h99999999;
        @(negedge clk);
        chk("chg_memwrite", 32'(bus.mem_memwrite), 32'd1);
        chk("chg_mem_addr", bus.mem_addr, 32'd8);
        chk("chg_mem_wdata", bus.mem_wdata, 32'h22220000);
        wait_ack(0, lat);
        chk("chg_remaining", 32'(lat), 32'd1);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        txn(0, 1'b0, 32'h20, 32'd0, 1'b0, 32'h22220000, lat);
        txn(1, 1'b0, 32'h24, 32'd0, 1'b0, 32'd0, lat);

        // Both requesters held: last owner was m1, so m0 first, then alternate
        @(posedge clk); #1;
        base = ack_cyc.size();
        push_exp(0, 1'b0, 32'hDEADBEEF);
        push_exp(1, 1'b0, 32'hA5A50001);
        push_exp(0, 1'b0, 32'hDEADBEEF);
        push_exp(1, 1'b0, 32'hA5A50001);
        set_req(0, 1'b1, 1'b0, 32'h10, 32'd0);
        set_req(1, 1'b1, 1'b0, 32'hFC, 32'd0);
        nack   = 0;
        n      = 0;
        idle_n = 0;
        while (nack < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (!bus.busy) idle_n++;
            if (bus.m0_ack || bus.m1_ack) nack++;
        end
        chk("rr_ack_count", 32'(nack), 32'd4);
        chk("rr_idle_cycles", 32'(idle_n), 32'd4);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
        if (ack_cyc.size() >= base + 4) begin
            for (int i = 1; i < 4; i++)
                chk($sformatf("rr_gap%0d", i), 32'(ack_cyc[base+i] - ack_cyc[base+i-1]), 32'd3);
        end

        // m1 alone, req held across four writes with fields updated during RESP
        @(posedge clk); #1;
        base = ack_cyc.size();
        w0   = wr_cnt;
        for (int k = 0; k < 4; k++) push_exp(1, 1'b0, 32'd0);
        set_req(1, 1'b1, 1'b1, 32'h40, 32'hB0000000);
        nack = 0;
        n    = 0;
        while (nack < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.m1_ack) begin
                nack++;
                bus.m1_addr  = 32'h40 + 32'(4 * nack);
                bus.m1_wdata = 32'hB0000000 + 32'(nack);
            end
        end
        chk("b2b_ack_count", 32'(nack), 32'd4);
        @(posedge clk); #1;
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("b2b_writes", 32'(wr_cnt - w0), 32'd4);
        if (ack_cyc.size() >= base + 4) begin
            for (int i = 1; i < 4; i++)
                chk($sformatf("b2b_gap%0d", i), 32'(ack_cyc[base+i] - ack_cyc[base+i-1]), 32'd3);
        end
        for (int k = 0; k < 4; k++)
            txn(0, 1'b0, 32'h40 + 32'(4 * k), 32'd0, 1'b0, 32'hB0000000 + 32'(k), lat);

        // Reset during ACCESS of an m0 write aborts it with no ack
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b1, 32'h30, 32'h30303030);
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_access", 32'(bus.mem_memwrite), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_memwrite", 32'(bus.mem_memwrite), 32'd0);
        chk("abort_memread",  32'(bus.mem_memread), 32'd0);
        chk("abort_mem_addr", bus.mem_addr, 32'd0);
        chk("abort_busy",     32'(bus.busy), 32'd0);
        chk("abort_m0_ack",   32'(bus.m0_ack), 32'd0);
        chk("abort_rsp",      bus.rsp_rdata, 32'd0);
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_req(1, 1'b1, 1'b0, 32'h30, 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_hold_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        push_exp(1, 1'b0, 32'd0);
        reset = 1'b0;
        wait_ack(1, lat);
        chk("post_rst_m1_latency", 32'(lat), 32'd3);
        @(posedge clk); #1;
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);

        // Fresh reset with both pending: m0 wins first
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        push_exp(0, 1'b0, 32'd0);
        push_exp(1, 1'b0, 32'd0);
        set_req(0, 1'b1, 1'b0, 32'h30, 32'd0);
        set_req(1, 1'b1, 1'b0, 32'h34, 32'd0);
        nack = 0;
        n    = 0;
        while (nack < 2 && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.m0_ack || bus.m1_ack) nack++;
        end
        chk("post_rst_both_acks", 32'(nack), 32'd2);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
